mfp_sram_arbiter: RTL and testbench
===================================

Name: mfp_sram_arbiter

Overview:
- Controller that shares the board's asynchronous SRAM between two requesters.
  - CPU requester: read/write, from the AHB-side SRAM slave.
  - VGA requester: read-only, from the framebuffer scan-out fetcher.
- Sequences each access as address setup, timed strobe, then recovery.
- Applies fixed VGA priority, with a starvation guard for the CPU.
- Sits between mfp_sys bus logic and the top-level SRAM pins; tristating of the data bus is done at the top level.

Parameters:
- ADDR_W, 20, SRAM word address width.
- ACCESS_CYC, 2, strobe-active cycles per access; must be ≥1.
- STARVE_MAX, 4, maximum consecutive VGA grants while the CPU waits; must be ≥1.

Ports:
- HCLK  in  1  system clock.
- HRESETn  in  1  reset; asynchronous, active-low.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_be  in  4  byte enables for writes.
- cpu_wdata  in  32  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read data; valid from cpu_ack until the next CPU read completes.
- vga_req  in  1  VGA read request; held until vga_ack.
- vga_addr  in  ADDR_W  VGA word address.
- vga_ack  out  1  one-cycle completion pulse.
- vga_rdata  out  32  read data; valid from vga_ack until the next VGA read completes.
- sram_addr  out  ADDR_W  SRAM address.
- sram_ce_n  out  3  chip enables, active-low.
- sram_oe_n  out  3  output enables, active-low.
- sram_we_n  out  3  write enables, active-low.
- sram_ub_n  out  3  upper-byte enables, active-low.
- sram_lb_n  out  3  lower-byte enables, active-low.
- sram_dout  out  48  write data to the pads.
- sram_dq_oe  out  1  1 = drive sram_dout onto the pads.
- sram_din  in  48  data from the pads.

Behaviour:
- Clocking and reset
  - The block has one clock, HCLK.
  - Reset HRESETn is asynchronous and active-low.
  - All outputs are registered, so strobes are glitch-free.
- Reset values
  - State IDLE, sram_addr 0.
  - sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n all 3'b111.
  - sram_dout 0, sram_dq_oe 0.
  - Both acks 0, both rdata 0, starvation counter 0.
  - Reset asserted mid-access deselects the SRAM immediately. No ack is issued for the aborted access.
- Data mapping: a 32-bit word spans chips 0 and 1.
  - sram_dout[31:0] carries data; sram_dout[47:32] = 0.
  - Chip 2 is held deselected: ce/oe/we/ub/lb bit 2 always 1.
  - Byte enables: be[0]→lb_n[0], be[1]→ub_n[0], be[2]→lb_n[1], be[3]→ub_n[1].
  - Reads enable all four bytes.
- FSM states: IDLE → SETUP → STROBE → RECOV → IDLE.
  - IDLE
    - If any request is present, pick a winner and latch its address, we, be and wdata. Go to SETUP.
    - If no request is present, stay in IDLE.
  - SETUP (1 cycle)
    - sram_addr is valid; ce_n[1:0] = 0.
    - Read: oe_n[1:0] = 0.
    - Write: sram_dout and sram_dq_oe = 1 are driven; oe_n stays high; we_n stays high.
  - STROBE (ACCESS_CYC cycles, down-counter)
    - Write: we_n[1:0] = 0.
    - Read: oe_n stays low; sram_din[31:0] is captured into the winner's rdata register on the last STROBE cycle.
  - RECOV (1 cycle)
    - we_n and oe_n return high; ce_n stays low.
    - Write data and dq_oe are held (hold time).
    - The winner's ack is pulsed.
  - On exit from RECOV: ce_n = 3'b111, dq_oe = 0.
- Latency: the ack is asserted ACCESS_CYC+2 cycles after the IDLE grant cycle. Throughput is one access per ACCESS_CYC+3 cycles.
- Handshake rules
  - The requester holds req and its payload stable from assertion until ack.
  - req must be low in the cycle after ack, unless it is a new request.
  - A req deasserted before ack is illegal; behaviour is undefined, but the FSM still completes the access.
- Arbitration (IDLE only)
  - VGA wins when both are requesting, unless streak == STARVE_MAX, in which case the CPU wins.
  - streak is incremented on a VGA grant while cpu_req = 1, saturating at STARVE_MAX.
  - streak is cleared on a CPU grant, and in any IDLE cycle with cpu_req = 0.
- A write is never merged or reordered. A CPU read after a CPU write to the same address returns the new data.

Test Plan:
- Reset then CPU write: cpu_req, we = 1, addr 0x00010, be 4'hF, wdata 0xDEADBEEF.
  - Required: SETUP with ce_n 3'b100; we_n 3'b100 for exactly 2 cycles; dq_oe high through RECOV; cpu_ack 4 cycles after grant.
  - Then a CPU read of 0x00010 returns 0xDEADBEEF on cpu_rdata at cpu_ack.
- Byte write with be 4'b0101.
  - Required: lb_n = 3'b100 and ub_n = 3'b111 during the strobe; a SRAM model keeps the unselected bytes.
- Simultaneous cpu_req and vga_req held continuously, STARVE_MAX = 4.
  - Required: grant order V,V,V,V,C,V,V,V,V,C; each ack pulses for exactly one cycle.
- vga_req only, back-to-back, ACCESS_CYC = 2.
  - Required: one vga_ack every 5 cycles; cpu_ack stays 0; streak stays 0.
- HRESETn driven low during a write STROBE.
  - Required: we_n/ce_n go to 3'b111 and dq_oe to 0 without waiting for a clock edge; no ack is issued; after release the FSM is in IDLE and a new request is served normally.
- ACCESS_CYC = 1 regression.
  - Required: read latency is 3 cycles; data is captured on the single STROBE cycle.

Source files
------------

// File: rtl/mfp_sram_arbiter.sv
// Async SRAM controller shared by a CPU (read/write) and a VGA scan-out fetcher (read-only).
// Each access runs SETUP, ACCESS_CYC strobe cycles, RECOV; VGA has priority with a CPU starvation guard.
module mfp_sram_arbiter #(
   parameter int ADDR_W     = 20,
   parameter int ACCESS_CYC = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [3:0]        cpu_be,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_ack,
   output logic [31:0]       cpu_rdata,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_ack,
   output logic [31:0]       vga_rdata,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [2:0]        sram_ce_n,
   output logic [2:0]        sram_oe_n,
   output logic [2:0]        sram_we_n,
   output logic [2:0]        sram_ub_n,
   output logic [2:0]        sram_lb_n,
   output logic [47:0]       sram_dout,
   output logic              sram_dq_oe,
   input  logic [47:0]       sram_din
);
   localparam int CNT_W = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
   localparam int STK_W = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOV} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [STK_W-1:0] streak;
   logic             cur_we;
   logic             cur_vga;
   logic             any_req;
   logic             starved;
   logic             cpu_wins;
   logic             unused_din;

   // Chip 2 is never used, so the upper pad bits carry nothing of interest.
   assign unused_din = ^sram_din[47:32];
   assign starved    = (streak == STK_W'(STARVE_MAX));
   assign any_req    = cpu_req | vga_req;
   assign cpu_wins   = cpu_req & (~vga_req | starved);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state      <= IDLE;
         cnt        <= '0;
         streak     <= '0;
         cur_we     <= 1'b0;
         cur_vga    <= 1'b0;
         cpu_ack    <= 1'b0;
         vga_ack    <= 1'b0;
         cpu_rdata  <= '0;
         vga_rdata  <= '0;
         sram_addr  <= '0;
         sram_ce_n  <= '1;
         sram_oe_n  <= '1;
         sram_we_n  <= '1;
         sram_ub_n  <= '1;
         sram_lb_n  <= '1;
         sram_dout  <= '0;
         sram_dq_oe <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         vga_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (!cpu_req)
                  streak <= '0;
               if (any_req) begin
                  state     <= SETUP;
                  sram_ce_n <= 3'b100;
                  if (cpu_wins) begin
                     cur_vga    <= 1'b0;
                     cur_we     <= cpu_we;
                     streak     <= '0;
                     sram_addr  <= cpu_addr;
                     sram_oe_n  <= cpu_we ? 3'b111 : 3'b100;
                     sram_dq_oe <= cpu_we;
                     if (cpu_we) begin
                        sram_dout <= {16'h0000, cpu_wdata};
                        sram_lb_n <= {1'b1, ~cpu_be[2], ~cpu_be[0]};
                        sram_ub_n <= {1'b1, ~cpu_be[3], ~cpu_be[1]};
                     end else begin
                        sram_lb_n <= 3'b100;
                        sram_ub_n <= 3'b100;
                     end
                  end else begin
                     cur_vga    <= 1'b1;
                     cur_we     <= 1'b0;
                     sram_addr  <= vga_addr;
                     sram_oe_n  <= 3'b100;
                     sram_dq_oe <= 1'b0;
                     sram_lb_n  <= 3'b100;
                     sram_ub_n  <= 3'b100;
                     if (cpu_req && !starved)
                        streak <= streak + 1'b1;
                  end
               end
            end
            SETUP: begin
               state <= STROBE;
               cnt   <= CNT_W'(ACCESS_CYC - 1);
               if (cur_we)
                  sram_we_n <= 3'b100;
            end
            STROBE: begin
               if (cnt == '0) begin
                  state     <= RECOV;
                  sram_we_n <= 3'b111;
                  sram_oe_n <= 3'b111;
                  cpu_ack   <= ~cur_vga;
                  vga_ack   <= cur_vga;
                  if (!cur_we) begin
                     if (cur_vga)
                        vga_rdata <= sram_din[31:0];
                     else
                        cpu_rdata <= sram_din[31:0];
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RECOV: begin
               state      <= IDLE;
               sram_ce_n  <= 3'b111;
               sram_ub_n  <= 3'b111;
               sram_lb_n  <= 3'b111;
               sram_dq_oe <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mfp_sram_arbiter.sv
// Bench for mfp_sram_arbiter: SRAM pad models, transaction-level reference memory and arbitration model,
// one instance with ACCESS_CYC=2 and a second with ACCESS_CYC=1.
module tb_mfp_sram_arbiter;
   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;

   logic        cpu_req, cpu_we, cpu_ack, vga_req, vga_ack, sram_dq_oe;
   logic [19:0] cpu_addr, vga_addr, sram_addr;
   logic [3:0]  cpu_be;
   logic [31:0] cpu_wdata, cpu_rdata, vga_rdata;
   logic [2:0]  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
   logic [47:0] sram_dout, sram_din;

   logic        a1_cpu_req, a1_cpu_we, a1_cpu_ack, a1_vga_req, a1_vga_ack, a1_sram_dq_oe;
   logic [19:0] a1_cpu_addr, a1_vga_addr, a1_sram_addr;
   logic [3:0]  a1_cpu_be;
   logic [31:0] a1_cpu_wdata, a1_cpu_rdata, a1_vga_rdata;
   logic [2:0]  a1_sram_ce_n, a1_sram_oe_n, a1_sram_we_n, a1_sram_ub_n, a1_sram_lb_n;
   logic [47:0] a1_sram_dout, a1_sram_din;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];
   logic        mem_ready = 1'b0;
   int          a1_oe_cnt = 0;
   logic [31:0] last_cpu_rd;

   logic [2:0]  obs_setup_ce, obs_setup_we, obs_setup_oe, obs_str_we, obs_str_lb, obs_str_ub;
   logic [2:0]  obs_rec_ce, obs_rec_we, obs_post_ce;
   logic        obs_setup_dq, obs_rec_dq, obs_post_ack, obs_post_dq;
   logic [47:0] obs_setup_dout;
   logic [31:0] obs_rdata;
   int          obs_we_cyc;

   always #5 HCLK = ~HCLK;

   mfp_sram_arbiter #(.ADDR_W(20), .ACCESS_CYC(2), .STARVE_MAX(4)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
      .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack), .vga_rdata(vga_rdata),
      .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .sram_dout(sram_dout),
      .sram_dq_oe(sram_dq_oe), .sram_din(sram_din)
   );

   mfp_sram_arbiter #(.ADDR_W(20), .ACCESS_CYC(1), .STARVE_MAX(4)) dut1 (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cpu_req(a1_cpu_req), .cpu_we(a1_cpu_we), .cpu_addr(a1_cpu_addr), .cpu_be(a1_cpu_be),
      .cpu_wdata(a1_cpu_wdata), .cpu_ack(a1_cpu_ack), .cpu_rdata(a1_cpu_rdata),
      .vga_req(a1_vga_req), .vga_addr(a1_vga_addr), .vga_ack(a1_vga_ack), .vga_rdata(a1_vga_rdata),
      .sram_addr(a1_sram_addr), .sram_ce_n(a1_sram_ce_n), .sram_oe_n(a1_sram_oe_n),
      .sram_we_n(a1_sram_we_n), .sram_ub_n(a1_sram_ub_n), .sram_lb_n(a1_sram_lb_n),
      .sram_dout(a1_sram_dout), .sram_dq_oe(a1_sram_dq_oe), .sram_din(a1_sram_din)
   );

   function automatic logic [31:0] init_word(input int unsigned i);
      return (i * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r = old_w;
      for (int unsigned i = 0; i < 4; i++)
         if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] pat(input logic [19:0] a);
      return {a[11:0], ~a};
   endfunction

   // Pad-level SRAM model for the main instance: 2 x16 chips, byte lanes, garbage when not driving.
   always @(negedge HCLK) begin
      logic [31:0] w;
      if (!mem_ready) begin
         for (int unsigned i = 0; i < 1024; i++) mem[i] = init_word(i);
         mem_ready = 1'b1;
      end
      if (!sram_ce_n[0] && !sram_we_n[0]) begin
         w = mem[sram_addr[9:0]];
         if (!sram_lb_n[0]) w[7:0]   = sram_dout[7:0];
         if (!sram_ub_n[0]) w[15:8]  = sram_dout[15:8];
         if (!sram_lb_n[1]) w[23:16] = sram_dout[23:16];
         if (!sram_ub_n[1]) w[31:24] = sram_dout[31:24];
         mem[sram_addr[9:0]] = w;
      end
      if (!sram_ce_n[0] && !sram_oe_n[0])
         sram_din = {16'($urandom), mem[sram_addr[9:0]]};
      else
         sram_din = {16'($urandom), 32'($urandom)};
   end

   // Second instance: data only valid on the second output-enabled cycle (slow access time).
   always @(negedge HCLK) begin
      if (!a1_sram_ce_n[0] && !a1_sram_oe_n[0]) a1_oe_cnt = a1_oe_cnt + 1;
      else a1_oe_cnt = 0;
      if (a1_oe_cnt == 2) a1_sram_din = {16'($urandom), pat(a1_sram_addr)};
      else a1_sram_din = {16'($urandom), 32'($urandom)};
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no summary, want summary");
      $fatal(1, "watchdog expired");
   end

   // Issues one CPU access from an IDLE cycle; returns latency in cycles after the grant cycle (-1 on timeout).
   task automatic cpu_access(input logic we, input logic [19:0] addr, input logic [3:0] be,
                             input logic [31:0] wd, output int lat);
      cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wd; cpu_req = 1'b1;
      lat = -1; obs_we_cyc = 0;
      obs_str_we = 3'b111; obs_str_lb = 3'b111; obs_str_ub = 3'b111;
      for (int n = 1; n <= 40; n++) begin
         @(negedge HCLK);
         if (n == 1) begin
            obs_setup_ce = sram_ce_n; obs_setup_we = sram_we_n; obs_setup_oe = sram_oe_n;
            obs_setup_dq = sram_dq_oe; obs_setup_dout = sram_dout;
         end
         if (sram_we_n !== 3'b111) begin
            obs_we_cyc++; obs_str_we = sram_we_n; obs_str_lb = sram_lb_n; obs_str_ub = sram_ub_n;
         end
         if (cpu_ack === 1'b1) begin
            lat = n; obs_rec_dq = sram_dq_oe; obs_rec_ce = sram_ce_n; obs_rec_we = sram_we_n;
            obs_rdata = cpu_rdata;
            break;
         end
      end
      cpu_req = 1'b0;
      @(negedge HCLK);
      obs_post_ack = cpu_ack; obs_post_ce = sram_ce_n; obs_post_dq = sram_dq_oe;
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      repeat (3) @(negedge HCLK);
      n_cmp++; if (sram_addr !== 20'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
      n_cmp++; if (sram_ce_n !== 3'b111) begin n_bad++; $display("FAIL reset_ce_n: got %b want 111", sram_ce_n); end
      n_cmp++; if (sram_oe_n !== 3'b111) begin n_bad++; $display("FAIL reset_oe_n: got %b want 111", sram_oe_n); end
      n_cmp++; if (sram_we_n !== 3'b111) begin n_bad++; $display("FAIL reset_we_n: got %b want 111", sram_we_n); end
      n_cmp++; if ({sram_ub_n, sram_lb_n} !== 6'b111111) begin n_bad++; $display("FAIL reset_ub_lb: got %b%b want 111111", sram_ub_n, sram_lb_n); end
      n_cmp++; if (sram_dout !== 48'h0) begin n_bad++; $display("FAIL reset_dout: got %h want 0", sram_dout); end
      n_cmp++; if (sram_dq_oe !== 1'b0) begin n_bad++; $display("FAIL reset_dq_oe: got %b want 0", sram_dq_oe); end
      n_cmp++; if ({cpu_ack, vga_ack} !== 2'b00) begin n_bad++; $display("FAIL reset_acks: got %b want 00", {cpu_ack, vga_ack}); end
      n_cmp++; if ({cpu_rdata, vga_rdata} !== 64'h0) begin n_bad++; $display("FAIL reset_rdata: got %h %h want 0 0", cpu_rdata, vga_rdata); end
      n_cmp++; if (a1_sram_ce_n !== 3'b111) begin n_bad++; $display("FAIL reset_a1_ce_n: got %b want 111", a1_sram_ce_n); end
      HRESETn = 1'b1;
      repeat (2) @(negedge HCLK);
      n_cmp++; if (sram_ce_n !== 3'b111) begin n_bad++; $display("FAIL idle_ce_n: got %b want 111", sram_ce_n); end
   endtask

   task automatic test_cpu_write();
      int lat;
      cpu_access(1'b1, 20'h00010, 4'hF, 32'hDEADBEEF, lat);
      ref_mem[16] = merge(ref_mem[16], 32'hDEADBEEF, 4'hF);
      n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL wr_latency: got %0d want 4", lat); end
      n_cmp++; if (obs_setup_ce !== 3'b100) begin n_bad++; $display("FAIL wr_setup_ce: got %b want 100", obs_setup_ce); end
      n_cmp++; if (obs_setup_we !== 3'b111) begin n_bad++; $display("FAIL wr_setup_we: got %b want 111", obs_setup_we); end
      n_cmp++; if (obs_setup_oe !== 3'b111) begin n_bad++; $display("FAIL wr_setup_oe: got %b want 111", obs_setup_oe); end
      n_cmp++; if (obs_setup_dq !== 1'b1) begin n_bad++; $display("FAIL wr_setup_dq: got %b want 1", obs_setup_dq); end
      n_cmp++; if (obs_setup_dout !== 48'h0000DEADBEEF) begin n_bad++; $display("FAIL wr_dout: got %h want 0000deadbeef", obs_setup_dout); end
      n_cmp++; if (obs_we_cyc != 2) begin n_bad++; $display("FAIL wr_we_cycles: got %0d want 2", obs_we_cyc); end
      n_cmp++; if (obs_str_we !== 3'b100) begin n_bad++; $display("FAIL wr_strobe_we: got %b want 100", obs_str_we); end
      n_cmp++; if ({obs_rec_dq, obs_rec_ce, obs_rec_we} !== 7'b1100111) begin n_bad++; $display("FAIL wr_recov: got dq=%b ce=%b we=%b want 1 100 111", obs_rec_dq, obs_rec_ce, obs_rec_we); end
      n_cmp++; if ({obs_post_ack, obs_post_dq, obs_post_ce} !== 5'b00111) begin n_bad++; $display("FAIL wr_exit: got ack=%b dq=%b ce=%b want 0 0 111", obs_post_ack, obs_post_dq, obs_post_ce); end
      cpu_access(1'b0, 20'h00010, 4'h0, 32'h0, lat);
      n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL rd_latency: got %0d want 4", lat); end
      n_cmp++; if (obs_setup_oe !== 3'b100) begin n_bad++; $display("FAIL rd_setup_oe: got %b want 100", obs_setup_oe); end
      n_cmp++; if (obs_we_cyc != 0) begin n_bad++; $display("FAIL rd_we_cycles: got %0d want 0", obs_we_cyc); end
      n_cmp++; if (obs_rdata !== ref_mem[16]) begin n_bad++; $display("FAIL rd_after_wr: got %h want %h", obs_rdata, ref_mem[16]); end
      last_cpu_rd = ref_mem[16];
   endtask

   task automatic test_byte_write();
      int lat;
      logic [31:0] d0, d1;
      d0 = $urandom; d1 = $urandom;
      cpu_access(1'b1, 20'h00021, 4'hF, d0, lat);
      ref_mem[33] = merge(ref_mem[33], d0, 4'hF);
      cpu_access(1'b1, 20'h00021, 4'b0101, d1, lat);
      ref_mem[33] = merge(ref_mem[33], d1, 4'b0101);
      n_cmp++; if (obs_str_lb !== 3'b100) begin n_bad++; $display("FAIL be_lb_n: got %b want 100", obs_str_lb); end
      n_cmp++; if (obs_str_ub !== 3'b111) begin n_bad++; $display("FAIL be_ub_n: got %b want 111", obs_str_ub); end
      cpu_access(1'b0, 20'h00021, 4'h0, 32'h0, lat);
      n_cmp++; if (obs_rdata !== ref_mem[33]) begin n_bad++; $display("FAIL be_readback: got %h want %h", obs_rdata, ref_mem[33]); end
      last_cpu_rd = ref_mem[33];
   endtask

   task automatic test_random_cpu();
      int lat;
      logic we;
      logic [19:0] a;
      logic [3:0] be;
      logic [31:0] d;
      for (int i = 0; i < 16; i++) begin
         we = 1'($urandom_range(0, 1)); a = 20'h30 + 20'($urandom_range(0, 7));
         be = 4'($urandom_range(1, 15)); d = $urandom;
         cpu_access(we, a, be, d, lat);
         n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want 4", i, lat); end
         if (we) begin
            ref_mem[a[9:0]] = merge(ref_mem[a[9:0]], d, be);
            n_cmp++; if (cpu_rdata !== last_cpu_rd) begin n_bad++; $display("FAIL rnd_rdata_hold[%0d]: got %h want %h", i, cpu_rdata, last_cpu_rd); end
         end else begin
            n_cmp++; if (obs_rdata !== ref_mem[a[9:0]]) begin n_bad++; $display("FAIL rnd_read[%0d] @%h: got %h want %h", i, a, obs_rdata, ref_mem[a[9:0]]); end
            last_cpu_rd = ref_mem[a[9:0]];
         end
      end
   endtask

   task automatic test_arbitration();
      byte order[$];
      byte want, got;
      int dbl = 0, both = 0, vk = 0, ck = 0, vrun = 0;
      logic pv = 1'b0, pc = 1'b0;
      cpu_we = 1'b0; cpu_addr = 20'h200; vga_addr = 20'h100;
      cpu_req = 1'b1; vga_req = 1'b1;
      for (int n = 0; n < 400 && order.size() < 10; n++) begin
         @(negedge HCLK);
         if (vga_ack && cpu_ack) both++;
         if ((vga_ack && pv) || (cpu_ack && pc)) dbl++;
         pv = vga_ack; pc = cpu_ack;
         if (vga_ack) begin
            order.push_back(8'h56);
            n_cmp++; if (vga_rdata !== ref_mem[vga_addr[9:0]]) begin n_bad++; $display("FAIL arb_vga_data @%h: got %h want %h", vga_addr, vga_rdata, ref_mem[vga_addr[9:0]]); end
            vk++; vga_addr = 20'h100 + 20'(vk);
         end
         if (cpu_ack) begin
            order.push_back(8'h43);
            n_cmp++; if (cpu_rdata !== ref_mem[cpu_addr[9:0]]) begin n_bad++; $display("FAIL arb_cpu_data @%h: got %h want %h", cpu_addr, cpu_rdata, ref_mem[cpu_addr[9:0]]); end
            last_cpu_rd = ref_mem[cpu_addr[9:0]];
            ck++; cpu_addr = 20'h200 + 20'(ck);
         end
      end
      cpu_req = 1'b0; vga_req = 1'b0;
      @(negedge HCLK);
      if (vga_ack || cpu_ack) dbl++;
      n_cmp++; if (order.size() != 10) begin n_bad++; $display("FAIL arb_grant_count: got %0d want 10", order.size()); end
      for (int i = 0; i < 10; i++) begin
         if (vrun == 4) begin want = 8'h43; vrun = 0; end
         else begin want = 8'h56; vrun++; end
         got = (i < order.size()) ? order[i] : 8'h2D;
         n_cmp++; if (got !== want) begin n_bad++; $display("FAIL arb_order[%0d]: got %c want %c", i, got, want); end
      end
      n_cmp++; if (dbl != 0) begin n_bad++; $display("FAIL arb_ack_width: got %0d long pulses want 0", dbl); end
      n_cmp++; if (both != 0) begin n_bad++; $display("FAIL arb_dual_ack: got %0d want 0", both); end
   endtask

   task automatic test_back_to_back();
      int t_last = 0, cpu_seen = 0, nack = 0;
      vga_addr = 20'h140; vga_req = 1'b1;
      for (int n = 1; n <= 60 && nack < 6; n++) begin
         @(negedge HCLK);
         if (cpu_ack) cpu_seen++;
         if (vga_ack) begin
            n_cmp++; if (vga_rdata !== ref_mem[vga_addr[9:0]]) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", nack, vga_rdata, ref_mem[vga_addr[9:0]]); end
            n_cmp++;
            if (nack == 0) begin
               if (n != 4) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 4", n); end
            end else if (n - t_last != 5) begin
               n_bad++; $display("FAIL b2b_interval[%0d]: got %0d want 5", nack, n - t_last);
            end
            t_last = n; nack++; vga_addr = 20'h140 + 20'(nack);
         end
      end
      vga_req = 1'b0;
      @(negedge HCLK);
      if (cpu_ack) cpu_seen++;
      n_cmp++; if (nack != 6) begin n_bad++; $display("FAIL b2b_ack_count: got %0d want 6", nack); end
      n_cmp++; if (cpu_seen != 0) begin n_bad++; $display("FAIL b2b_cpu_ack: got %0d want 0", cpu_seen); end
   endtask

   task automatic test_reset_mid_write();
      int lat, ackcnt = 0;
      logic seen = 1'b0;
      logic [31:0] d;
      cpu_we = 1'b1; cpu_addr = 20'h003F0; cpu_be = 4'hF; cpu_wdata = $urandom; cpu_req = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge HCLK);
         if (sram_we_n[0] === 1'b0) begin seen = 1'b1; break; end
      end
      n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rst_strobe_reached: got %b want 1", seen); end
      #2 HRESETn = 1'b0;
      #1;
      n_cmp++; if ({sram_we_n, sram_ce_n, sram_oe_n} !== 9'h1FF) begin n_bad++; $display("FAIL rst_async_strobes: got we=%b ce=%b oe=%b want 111 111 111", sram_we_n, sram_ce_n, sram_oe_n); end
      n_cmp++; if (sram_dq_oe !== 1'b0) begin n_bad++; $display("FAIL rst_async_dq_oe: got %b want 0", sram_dq_oe); end
      cpu_req = 1'b0;
      repeat (3) begin @(negedge HCLK); if (cpu_ack) ackcnt++; end
      HRESETn = 1'b1;
      repeat (2) begin @(negedge HCLK); if (cpu_ack) ackcnt++; end
      n_cmp++; if (ackcnt != 0) begin n_bad++; $display("FAIL rst_no_ack: got %0d acks want 0", ackcnt); end
      d = $urandom;
      cpu_access(1'b1, 20'h003F1, 4'hF, d, lat);
      ref_mem[10'h3F1] = merge(ref_mem[10'h3F1], d, 4'hF);
      n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL rst_after_wr_latency: got %0d want 4", lat); end
      cpu_access(1'b0, 20'h003F1, 4'h0, 32'h0, lat);
      n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL rst_after_rd_latency: got %0d want 4", lat); end
      n_cmp++; if (obs_rdata !== ref_mem[10'h3F1]) begin n_bad++; $display("FAIL rst_after_rd_data: got %h want %h", obs_rdata, ref_mem[10'h3F1]); end
   endtask

   task automatic a1_access(input logic is_vga, input logic [19:0] addr, output int lat,
                            output logic [31:0] rd, output logic [5:0] strobe_ublb,
                            output logic drove);
      if (is_vga) begin a1_vga_addr = addr; a1_vga_req = 1'b1; end
      else begin a1_cpu_addr = addr; a1_cpu_we = 1'b0; a1_cpu_req = 1'b1; end
      lat = -1; rd = '0; strobe_ublb = '1; drove = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge HCLK);
         if (a1_sram_dq_oe || a1_sram_we_n !== 3'b111) drove = 1'b1;
         if (n == 2) strobe_ublb = {a1_sram_ub_n, a1_sram_lb_n};
         if (is_vga ? a1_vga_ack : a1_cpu_ack) begin
            lat = n; rd = is_vga ? a1_vga_rdata : a1_cpu_rdata;
            break;
         end
      end
      a1_vga_req = 1'b0; a1_cpu_req = 1'b0;
      @(negedge HCLK);
   endtask

   task automatic test_access1();
      int lat;
      logic [31:0] rd;
      logic [5:0] ublb;
      logic drove;
      logic [19:0] addrs [3];
      addrs[0] = 20'h00055; addrs[1] = 20'hABCDE; addrs[2] = 20'h12345;
      for (int i = 0; i < 3; i++) begin
         a1_access(i == 2, addrs[i], lat, rd, ublb, drove);
         n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL ac1_latency[%0d]: got %0d want 3", i, lat); end
         n_cmp++; if (rd !== pat(addrs[i])) begin n_bad++; $display("FAIL ac1_data[%0d]: got %h want %h", i, rd, pat(addrs[i])); end
         n_cmp++; if (ublb !== 6'b100100) begin n_bad++; $display("FAIL ac1_byte_en[%0d]: got %b want 100100", i, ublb); end
         n_cmp++; if (drove !== 1'b0) begin n_bad++; $display("FAIL ac1_read_drove_bus[%0d]: got %b want 0", i, drove); end
      end
      n_cmp++; if (a1_sram_dout !== 48'h0) begin n_bad++; $display("FAIL ac1_dout: got %h want 0", a1_sram_dout); end
   endtask

   initial begin
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
      vga_req = 1'b0; vga_addr = '0;
      a1_cpu_req = 1'b0; a1_cpu_we = 1'b0; a1_cpu_addr = '0; a1_cpu_be = '0; a1_cpu_wdata = '0;
      a1_vga_req = 1'b0; a1_vga_addr = '0;
      last_cpu_rd = '0;
      for (int unsigned i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      test_reset();
      test_cpu_write();
      test_byte_write();
      test_random_cpu();
      test_arbitration();
      test_back_to_back();
      test_reset_mid_write();
      test_access1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
